str_frame_acc: RTL
==================

# str_frame_acc

Streaming frame accumulator, placed directly downstream of the multiplier and adder stages (`str_mul`, `str_fpmul`, `str_multiin_addsub`). It sums every signed sample of an `ilast`-delimited frame and emits one scaled, optionally saturated result per frame, together with that frame's sample count. Typical uses are dot-product / MAC completion and block energy sums. It uses the team's valid/ready/last stream handshake.

## Interface
- `DW`, 16: input sample width, signed.
- `ODW`, 32: output result width, signed.
- `MAXLEN`, 1024: maximum supported frame length in samples, ≥1.
- `SHIFT`, 0: arithmetic right shift applied to the final sum, ≥0.
- `SAT`, 1: 1 = saturate the shifted sum to ODW; 0 = truncate to the low ODW bits.
- Derived: `CW = $clog2(MAXLEN+1)`, `AW = DW + $clog2(MAXLEN)`, internal accumulator width.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst_n`  in  1  synchronous reset, active low.
- `idata`  in  DW  signed input sample.
- `ilast`  in  1  marks the last sample of a frame.
- `ivalid`  in  1  input valid.
- `iready`  out  1  input ready.
- `odata`  out  ODW  signed frame result.
- `ocnt`  out  CW  number of samples in the frame, saturating at MAXLEN.
- `oerr`  out  1  frame had more than MAXLEN samples.
- `olast`  out  1  high whenever `ovalid` is high; each result is a one-beat frame.
- `ovalid`  out  1  output valid.
- `oready`  in  1  output ready.

## Operation
- Definitions: `ish = ivalid & iready`; `osh = ovalid & oready`.
- `iready = ~ilast | ~ovalid | oready`.
  - Non-last samples are always accepted, even while a result is pending.
  - A last sample stalls only while an unconsumed result occupies the output register.
- Internal state:
  - `acc` (AW bits, signed).
  - `cnt` (CW bits).
  - `ovf` (1 bit).
- On `ish` with `ilast=0`:
  - `acc <= acc + sext(idata)`, wrapping modulo 2^AW.
  - `cnt <= cnt+1`, saturating at MAXLEN.
  - If `cnt == MAXLEN`, then `ovf <= 1`.
- On `ish` with `ilast=1`:
  - Compute `sum = acc + sext(idata)`.
  - Compute `s = sum >>> SHIFT`. This is floor; there is no rounding.
  - `odata <= SAT ? clamp(s, -2^(ODW-1), 2^(ODW-1)-1) : s[ODW-1:0]`.
  - `ocnt <= min(cnt+1, MAXLEN)`.
  - `oerr <= ovf | (cnt == MAXLEN)`.
  - `ovalid <= 1`.
  - In the same cycle, clear `acc`, `cnt` and `ovf` to 0, ready for the next frame.
- If ODW ≥ AW-SHIFT, saturation cannot trigger and is not built; the value is sign-extended instead.
- `ovalid` update:
  - Set to 1 on a last-sample `ish`.
  - Otherwise cleared to 0 on `osh`.
  - Otherwise held.
- `odata`, `ocnt` and `oerr` change only on a last-sample `ish`. They stay stable while `ovalid & ~oready`.
- Simultaneous `osh` and last-sample `ish`: the new result replaces the old one and `ovalid` stays 1. This gives full throughput with no bubble.
- Frames longer than MAXLEN:
  - `acc` may wrap, so `odata` is only guaranteed correct for in-range sums.
  - `oerr=1` flags the frame.
- Reset (`rst_n=0` at a clock edge): `ovalid=0`, `odata=0`, `ocnt=0`, `oerr=0`, `olast=0`, `acc=0`, `cnt=0`, `ovf=0`.
  - A partial frame in progress is discarded.
  - A pending result is dropped.
  - `iready` follows its combinational equation; with `ovalid=0` it is 1 during and after reset.

## Timing
- Latency: the result is valid on the cycle after the last sample's handshake.
- Throughput: one sample per clock.
- Single-sample frames are sustained back-to-back, one result per clock, when `oready=1`.
- `iready` is combinational from `ilast`, `ovalid` and `oready`.
  - There is no combinational path from `idata`/`ivalid` to any output.
  - Upstream must not make `ivalid` depend on `iready`.
- All outputs except `iready` are registered.

## Test plan
Common settings: DW=16, ODW=16, MAXLEN=8, SAT=1, SHIFT=0 unless noted; `oready=1` unless noted.
1. Basic frame: feed 1, 2, 3, 4 with last on 4, one sample per cycle → exactly one cycle after the 4 is accepted, `odata=10`, `ocnt=4`, `oerr=0`, `olast=1`, `ovalid=1`.
2. Back-to-back frames: feed [-5 last], then [7, -7 last] on consecutive cycles → results `-5`/cnt 1 and `0`/cnt 2; `iready` stays 1 throughout with no gap.
3. Saturation, SAT=1: four samples of 30000 → `odata=32767`; four samples of -30000 → `odata=-32768`. With SHIFT=2, samples 1, 2 → `odata=0`; samples -1, -2 → `odata=-1` (floor).
4. Backpressure: hold `oready=0` after a result of 10 is produced; send a next frame of 5, 5, 5(last).
   - The two non-last 5s are accepted.
   - `iready=0` while the last 5 is presented.
   - `odata` stays 10.
   - Raise `oready` → 10 is consumed, the last sample is accepted, and the next result is `odata=15`, `ocnt=3`.
5. Over-length frame: ten samples of 1, last on the tenth → `odata=10`, `ocnt=8`, `oerr=1`. The following frame [2 last] → `oerr=0`, `ocnt=1`.
6. Reset mid-frame: accept samples 100, 100, then assert `rst_n=0` for one cycle, then send [3 last] → `ovalid=0` during reset; the next result is `odata=3`, `ocnt=1`. A result pending at reset is never presented.

Source files
------------

// File: rtl/str_frame_acc.sv
// -----------------------------------------------------------------------------
// str_frame_acc
//
// Streaming frame accumulator. Sums every signed sample of an ilast-delimited
// input frame and emits one result beat per frame. The result is the frame sum,
// arithmetically shifted right by SHIFT (floor), then either saturated or
// truncated to ODW bits. The result beat also carries the frame's sample count
// and an over-length flag.
//
// Handshake (both sides): a beat transfers on a rising clk edge where
// valid & ready are both high. Once valid is raised, it holds with stable data
// until that transfer. valid never depends combinationally on ready.
//
// Parameters:
//   DW      input sample width (signed)
//   ODW     output result width (signed)
//   MAXLEN  longest frame counted exactly; longer frames raise oerr
//   SHIFT   arithmetic right shift applied to the final sum
//   SAT     1: clamp to the ODW signed range, 0: keep the low ODW bits
//
// Ports:
//   clk     clock, rising edge
//   rst_n   synchronous reset, active low
//   idata   signed input sample
//   ilast   last sample of the frame
//   ivalid  input valid
//   iready  input ready (combinational from ilast, ovalid, oready)
//   odata   signed frame result (registered)
//   ocnt    samples in the frame, saturating at MAXLEN (registered)
//   oerr    frame exceeded MAXLEN samples (registered)
//   olast   always equal to ovalid; each result is a one-beat frame
//   ovalid  output valid (registered)
//   oready  output ready
// -----------------------------------------------------------------------------
module str_frame_acc #(
   parameter int DW     = 16,
   parameter int ODW    = 32,
   parameter int MAXLEN = 1024,
   parameter int SHIFT  = 0,
   parameter int SAT    = 1,
   localparam int CW    = $clog2(MAXLEN + 1),
   localparam int AW    = DW + $clog2(MAXLEN)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic signed [DW-1:0]  idata,
   input  logic                  ilast,
   input  logic                  ivalid,
   output logic                  iready,
   output logic signed [ODW-1:0] odata,
   output logic        [CW-1:0]  ocnt,
   output logic                  oerr,
   output logic                  olast,
   output logic                  ovalid,
   input  logic                  oready
);

   // The clamp is only needed when the shifted sum can be wider than the
   // output. Otherwise, the low ODW bits of the sign-extended value are exact.
   localparam bit SAT_BUILT = (SAT != 0) && (ODW < (AW - SHIFT));

   // Width used to view the shifted sum next to the output. It must be at
   // least ODW so that sign extension into the output is a plain slice.
   localparam int EW = (ODW > AW) ? ODW : AW;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic signed [AW-1:0]  acc_q, acc_d;
   logic        [CW-1:0]  cnt_q, cnt_d;
   logic                  ovf_q, ovf_d;
   logic signed [ODW-1:0] odata_q, odata_d;
   logic        [CW-1:0]  ocnt_q, ocnt_d;
   logic                  oerr_q, oerr_d;
   logic                  ovalid_q, ovalid_d;

   // ---------------------------------------------------------------------------
   // Handshake
   // ---------------------------------------------------------------------------
   logic ish;
   logic osh;

   // Body samples never touch the output register, so they always flow.
   // A last sample needs the output register. It can enter only when that
   // register is empty or is being drained in this same cycle.
   assign iready = ~ilast | ~ovalid_q | oready;
   assign ish    = ivalid & iready;
   assign osh    = ovalid_q & oready;

   // ---------------------------------------------------------------------------
   // Datapath: running sum, count, scaling
   // ---------------------------------------------------------------------------
   logic signed [AW-1:0]  samp_ext;
   logic signed [AW-1:0]  sum;
   logic signed [AW-1:0]  shifted;
   logic        [CW-1:0]  cnt_inc;
   logic                  cnt_full;
   logic signed [EW-1:0]  wide;
   logic        [EW-ODW:0] wide_hi;
   logic signed [ODW-1:0] scaled;

   always_comb begin
      samp_ext = AW'(idata);
      // The sum wraps modulo 2^AW. This is exact for any frame of up to
      // MAXLEN samples.
      sum      = acc_q + samp_ext;
      shifted  = sum >>> SHIFT;

      cnt_full = (cnt_q == CW'(MAXLEN));
      cnt_inc  = cnt_full ? cnt_q : cnt_q + CW'(1);
   end

   always_comb begin
      wide    = EW'(shifted);
      // These bits, down to and including the output sign position, must all
      // match. If they do, the value fits in ODW bits.
      wide_hi = wide[EW-1:ODW-1];
      scaled  = wide[ODW-1:0];
      if (SAT_BUILT) begin
         if (!((wide_hi == '0) || (wide_hi == '1))) begin
            scaled = wide[EW-1] ? {1'b1, {(ODW-1){1'b0}}}
                                : {1'b0, {(ODW-1){1'b1}}};
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      odata_d  = odata_q;
      ocnt_d   = ocnt_q;
      oerr_d   = oerr_q;
      ovalid_d = ovalid_q;

      if (ish && !ilast) begin
         acc_d = sum;
         cnt_d = cnt_inc;
         // Count is already pinned at MAXLEN, so this sample is one too many.
         if (cnt_full) begin
            ovf_d = 1'b1;
         end
      end

      if (ish && ilast) begin
         odata_d  = scaled;
         ocnt_d   = cnt_inc;
         oerr_d   = ovf_q | cnt_full;
         // If the old result is draining this cycle (osh), it is replaced
         // here, so ovalid stays high with no bubble.
         ovalid_d = 1'b1;
         acc_d    = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
      end else if (osh) begin
         ovalid_d = 1'b0;
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q    <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         odata_q  <= '0;
         ocnt_q   <= '0;
         oerr_q   <= 1'b0;
         ovalid_q <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         odata_q  <= odata_d;
         ocnt_q   <= ocnt_d;
         oerr_q   <= oerr_d;
         ovalid_q <= ovalid_d;
      end
   end

   assign odata  = odata_q;
   assign ocnt   = ocnt_q;
   assign oerr   = oerr_q;
   assign ovalid = ovalid_q;
   assign olast  = ovalid_q;

endmodule
